risk_gate: RTL and testbench

- Parametrised pre-trade risk gate between the strategy/order generator and the order encoder.
- Checks each candidate order against a price band, a max order quantity, a net position limit, an order-rate throttle and a kill switch.
- Approved orders leave on a valid/ready stream; rejected orders raise a one-cycle reject pulse with a reason code.
- Tracks the projected net position from approved orders.

---
 rtl/risk_gate.sv | 127 ++++++++++++
 tb/tb_risk_gate.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risk_gate.sv
// risk_gate: pre-trade risk gate (price band, max qty, position limit, rate throttle, kill switch).
// Define RISK_STATS_EN to add saturating approved_cnt/rejected_cnt outputs.
module risk_gate #(
    parameter int PRICE_W     = 32,
    parameter int QTY_W       = 16,
    parameter int ORDER_W     = 64,
    parameter int POS_W       = 32,
    parameter int RATE_WINDOW = 1024,
    parameter int RATE_MAX    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRICE_W-1:0] risk_min,
    input  logic [PRICE_W-1:0] risk_max,
    input  logic [QTY_W-1:0]   max_qty,
    input  logic [POS_W-1:0]   pos_limit,
    input  logic               kill,
    input  logic [ORDER_W-1:0] in_order,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ORDER_W-1:0] out_order,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               rej_valid,
    output logic [2:0]         rej_code,
    output logic [POS_W-1:0]   position
`ifdef RISK_STATS_EN
   ,output logic [31:0]        approved_cnt,
    output logic [31:0]        rejected_cnt
`endif
);
    localparam int WC_W = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
    localparam int RC_W = $clog2(RATE_MAX + 1);

    logic               s1_valid_q;
    logic [ORDER_W-1:0] s1_order_q;
    logic               out_valid_q;
    logic [ORDER_W-1:0] out_order_q;
    logic               rej_valid_q;
    logic [2:0]         rej_code_q;
    logic [POS_W-1:0]   position_q, position_d;
    logic [WC_W-1:0]    wc_q, wc_d;
    logic [RC_W-1:0]    rate_q, rate_d;

    logic               advance, evaluate, take, wrap, buy;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
    logic [POS_W:0]     pos_x, qty_x, proj, mag;
    logic [2:0]         code;

    always_comb begin
        advance    = !out_valid_q || out_ready;
        price      = s1_order_q[PRICE_W-1:0];
        qty        = s1_order_q[PRICE_W+QTY_W-1:PRICE_W];
        buy        = s1_order_q[ORDER_W-1];
        // One extra bit so the projected position cannot wrap before the limit compare
        pos_x      = {position_q[POS_W-1], position_q};
        qty_x      = (POS_W+1)'(qty);
        proj       = buy ? pos_x + qty_x : pos_x - qty_x;
        mag        = proj[POS_W] ? -proj : proj;
        code       = kill                                 ? 3'd1 :
                     (price < risk_min || price > risk_max) ? 3'd2 :
                     (qty == '0 || qty > max_qty)           ? 3'd3 :
                     (mag > {1'b0, pos_limit})              ? 3'd4 :
                     (rate_q == RC_W'(RATE_MAX))            ? 3'd5 : 3'd0;
        evaluate   = advance && s1_valid_q;
        take       = evaluate && code == 3'd0;
        wrap       = wc_q == WC_W'(RATE_WINDOW - 1);
        wc_d       = wrap ? '0 : wc_q + WC_W'(1);
        rate_d     = wrap ? RC_W'(take) : rate_q + RC_W'(take);
        position_d = take ? proj[POS_W-1:0] : position_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_order_q  <= '0;
            out_valid_q <= 1'b0;
            out_order_q <= '0;
            rej_valid_q <= 1'b0;
            rej_code_q  <= '0;
            position_q  <= '0;
            wc_q        <= '0;
            rate_q      <= '0;
        end else begin
            wc_q        <= wc_d;
            rate_q      <= rate_d;
            position_q  <= position_d;
            rej_valid_q <= evaluate && !take;
            if (evaluate && !take)
                rej_code_q <= code;
            if (advance) begin
                s1_order_q  <= in_order;
                s1_valid_q  <= in_valid;
                out_valid_q <= take;
                if (take)
                    out_order_q <= s1_order_q;
            end
        end
    end

`ifdef RISK_STATS_EN
    logic [31:0] appr_q, rejc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            appr_q <= '0;
            rejc_q <= '0;
        end else begin
            if (take && appr_q != '1)
                appr_q <= appr_q + 32'd1;
            if (evaluate && !take && rejc_q != '1)
                rejc_q <= rejc_q + 32'd1;
        end
    end

    assign approved_cnt = appr_q;
    assign rejected_cnt = rejc_q;
`endif

    assign in_ready  = advance;
    assign out_order = out_order_q;
    assign out_valid = out_valid_q;
    assign rej_valid = rej_valid_q;
    assign rej_code  = rej_code_q;
    assign position  = position_q;
endmodule

// File: tb/tb_risk_gate.sv
// tb_risk_gate: directed and randomized checks of risk_gate against a transaction-level model.
module tb_risk_gate;
    localparam int W    = 32;
    localparam int MAXR = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] risk_min, risk_max;
    logic [15:0] max_qty;
    logic [31:0] pos_limit;
    logic        kill;
    logic [63:0] in_order;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_order;
    logic        out_valid;
    logic        out_ready;
    logic        rej_valid;
    logic [2:0]  rej_code;
    logic [31:0] position;
`ifdef RISK_STATS_EN
    logic [31:0] approved_cnt, rejected_cnt;
`endif

    always #5 clk = ~clk;

    risk_gate #(.RATE_WINDOW(W), .RATE_MAX(MAXR)) dut (
        .clk(clk), .reset(reset), .risk_min(risk_min), .risk_max(risk_max),
        .max_qty(max_qty), .pos_limit(pos_limit), .kill(kill),
        .in_order(in_order), .in_valid(in_valid), .in_ready(in_ready),
        .out_order(out_order), .out_valid(out_valid), .out_ready(out_ready),
        .rej_valid(rej_valid), .rej_code(rej_code), .position(position)
`ifdef RISK_STATS_EN
       ,.approved_cnt(approved_cnt), .rejected_cnt(rejected_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: pipeline contents, position as a plain integer,
    // approvals tallied per throttle window index.
    bit          m_s1_v, m_out_v, m_rej_v;
    logic [63:0] m_s1_o, m_out_o;
    logic [2:0]  m_rej_c;
    longint      m_pos;
    int          n;
    int          win_cnt[int];
    int          m_appr, m_rejn;
    int          rej_seen[8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic longint spos();
        return longint'($signed(position));
    endfunction

    function automatic logic [63:0] mk(bit buy, int q, int p);
        return {buy, 15'($urandom), 16'(q), 32'(p)};
    endfunction

    function automatic int reason(logic [63:0] o);
        logic [31:0] p = o[31:0];
        longint q = {48'd0, o[47:32]};
        longint lim = {32'd0, pos_limit};
        longint proj = o[63] ? m_pos + q : m_pos - q;
        if (kill) return 1;
        if (p < risk_min || p > risk_max) return 2;
        if (q == 0 || q > longint'({48'd0, max_qty})) return 3;
        if ((proj < 0 ? -proj : proj) > lim) return 4;
        if ((win_cnt.exists(n / W) ? win_cnt[n / W] : 0) >= MAXR) return 5;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1_v = 0; m_out_v = 0; m_rej_v = 0;
        m_s1_o = '0; m_out_o = '0; m_rej_c = '0;
        m_pos = 0; n = 0; m_appr = 0; m_rejn = 0;
        win_cnt.delete();
        for (int i = 0; i < 8; i++) rej_seen[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_rej_valid", 64'(rej_valid), 64'(0));
        chk("rst_position", 64'(position), 64'(0));
        chk("rst_out_order", out_order, 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive at the negedge, check in_ready, advance the model at the edge, check outputs.
    task automatic step(input bit v, input logic [63:0] o, input bit rdy);
        bit adv, rej;
        int c;
        longint q;
        in_valid = v;
        in_order = o;
        out_ready = rdy;
        adv = !m_out_v || rdy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(adv));
        @(posedge clk);
        rej = 0;
        if (adv) begin
            if (m_s1_v) begin
                c = reason(m_s1_o);
                if (c == 0) begin
                    q = {48'd0, m_s1_o[47:32]};
                    m_out_o = m_s1_o;
                    m_out_v = 1;
                    m_pos = m_s1_o[63] ? m_pos + q : m_pos - q;
                    win_cnt[(n + 1) / W]++;
                    m_appr++;
                end else begin
                    m_out_v = 0;
                    rej = 1;
                    m_rej_c = 3'(c);
                    m_rejn++;
                end
            end else
                m_out_v = 0;
            m_s1_v = v;
            m_s1_o = o;
        end
        m_rej_v = rej;
        n++;
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_out_v));
        chk("out_order", out_order, m_out_o);
        chk("rej_valid", 64'(rej_valid), 64'(m_rej_v));
        chk("rej_code", 64'(rej_code), 64'(m_rej_c));
        chk("position", 64'(spos()), 64'(m_pos));
        if (rej_valid === 1'b1) rej_seen[rej_code]++;
        @(negedge clk);
    endtask

    task automatic idle(input int k, input bit rdy);
        repeat (k) step(0, '0, rdy);
    endtask

    initial begin
        logic [63:0] a, b;
        risk_min = 100; risk_max = 200; max_qty = 50; pos_limit = 100;
        kill = 0; in_order = '0; in_valid = 0; out_ready = 1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single approved buy, two-cycle latency
        a = mk(1, 10, 150);
        step(1, a, 1);
        step(0, '0, 1);
        chk("t1_out_valid", 64'(out_valid), 64'(1));
        chk("t1_out_order", out_order, a);
        chk("t1_position", 64'(spos()), 64'(10));
        idle(2, 1);

        // Price and quantity rejects
        do_reset();
        step(1, mk(1, 10, 201), 1);
        step(1, mk(1, 0, 150), 1);
        step(1, mk(1, 51, 150), 1);
        idle(3, 1);
        chk("t2_code2", 64'(rej_seen[2]), 64'(1));
        chk("t2_code3", 64'(rej_seen[3]), 64'(2));
        chk("t2_position", 64'(spos()), 64'(0));

        // Position limit with back-to-back sells
        do_reset();
        repeat (5) step(1, mk(0, 50, 150), 1);
        idle(2, 1);
        chk("t3_position", 64'(spos()), 64'(-100));
        chk("t3_code4", 64'(rej_seen[4]), 64'(3));

        // Output stall holds order and s1
        do_reset();
        a = mk(1, 5, 120);
        b = mk(0, 3, 180);
        step(1, a, 1);
        step(1, b, 0);
        idle(3, 0);
        chk("t4_held_order", out_order, a);
        chk("t4_in_ready", 64'(in_ready), 64'(0));
        step(0, '0, 1);
        chk("t4_second_order", out_order, b);
        chk("t4_second_valid", 64'(out_valid), 64'(1));
        idle(2, 1);

        // Rate throttle and window wrap
        do_reset();
        repeat (6) step(1, mk(1, 1, 150), 1);
        idle(2, 1);
        chk("t5_position", 64'(spos()), 64'(4));
        chk("t5_code5", 64'(rej_seen[5]), 64'(2));
        idle(30, 1);
        step(1, mk(1, 1, 150), 1);
        idle(2, 1);
        chk("t5_after_wrap", 64'(spos()), 64'(5));

        // Kill outranks every other reason
        kill = 1;
        step(1, mk(1, 0, 999), 1);
        step(0, '0, 1);
        chk("t6_rej_valid", 64'(rej_valid), 64'(1));
        chk("t6_code1", 64'(rej_code), 64'(1));
        kill = 0;
        idle(1, 1);

        // Reset while an approved order is held
        do_reset();
        step(1, mk(0, 20, 110), 1);
        idle(2, 0);
        chk("t7_pre_valid", 64'(out_valid), 64'(1));
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                max_qty = 16'($urandom_range(20, 60));
                pos_limit = $urandom_range(40, 150);
            end
            kill = ($urandom_range(0, 99) < 4);
            step($urandom_range(0, 9) < 8,
                 mk($urandom_range(0, 1) == 1, $urandom_range(0, 55), $urandom_range(90, 210)),
                 $urandom_range(0, 9) < 7);
        end
        kill = 0;
        idle(3, 1);
`ifdef RISK_STATS_EN
        chk("stats_approved", 64'(approved_cnt), 64'(m_appr));
        chk("stats_rejected", 64'(rejected_cnt), 64'(m_rejn));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
